// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - opcode map, ALU codes, field widths and FSM encoding
package instr_encoder_loader_pkg;

    localparam int OPC_W    = 5;
    localparam int ALU_OP_W = 2;

    // Opcode map shared with the control unit's decoder
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd3;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd4;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'd6;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'd7;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'd8;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'd3;

    // Immediate forms sit exactly one ALU-class block above the register forms
    localparam logic [OPC_W-1:0] OPC_IMM_BIAS = OP_ADDI - OP_ADD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [OPC_W-1:0] encode_opcode(
        input logic                nop,
        input logic [ALU_OP_W-1:0] alu_op,
        input logic                use_imm
    );
        if (nop) begin
            return OP_NOP;
        end
        return OP_ADD + {{(OPC_W-ALU_OP_W){1'b0}}, alu_op} + (use_imm ? OPC_IMM_BIAS : '0);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// rtl/instr_encoder_loader_sync_fifo.sv - registered synchronous FIFO with full/empty flags
module instr_encoder_loader_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the index bits match
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction requests and streams them into instruction memory
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int IMM_W     = INSTR_W - OPC_W - 2*REG_AW
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_start,
    input  logic [ADDR_W-1:0]   in_base_addr,
    input  logic                in_req_valid,
    output logic                out_req_ready,
    input  logic                in_req_nop,
    input  logic [1:0]          in_req_alu_op,
    input  logic                in_req_use_imm,
    input  logic [REG_AW-1:0]   in_req_rd,
    input  logic [REG_AW-1:0]   in_req_rs,
    input  logic [REG_AW-1:0]   in_req_rt,
    input  logic [IMM_W-1:0]    in_req_imm,
    input  logic                in_req_last,
    output logic                out_mem_wr_en,
    output logic [ADDR_W-1:0]   out_mem_addr,
    output logic [INSTR_W-1:0]  out_mem_wr_data,
    input  logic                in_mem_ready,
    output logic                out_busy,
    output logic                out_done,
    output logic [ADDR_W:0]     out_count
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     count;
    logic                last_seen;

    logic [OPC_W-1:0]    opcode;
    logic [IMM_W-1:0]    operand;
    logic [INSTR_W-1:0]  enc_word;

    logic                fifo_full;
    logic                fifo_empty;
    logic [INSTR_W:0]    fifo_head;
    logic                accept;
    logic                write_fire;
    logic                head_last;

    assign opcode   = encode_opcode(in_req_nop, in_req_alu_op, in_req_use_imm);
    assign operand  = in_req_use_imm ? in_req_imm : {{(IMM_W-REG_AW){1'b0}}, in_req_rt};
    assign enc_word = in_req_nop ? '0 : {opcode, in_req_rd, in_req_rs, operand};

    assign accept     = in_req_valid && out_req_ready;
    assign write_fire = out_mem_wr_en && in_mem_ready;
    assign head_last  = fifo_head[INSTR_W];

    instr_encoder_loader_sync_fifo #(
        .WIDTH (INSTR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (in_clk),
        .rst       (in_rst),
        .push      (accept),
        .push_data ({in_req_last, enc_word}),
        .pop       (write_fire),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_start) state_nxt = ST_LOAD;
            ST_LOAD: if (write_fire && head_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshakes are masked during reset so no write or accept escapes in that cycle
    always_comb begin
        out_req_ready   = 1'b0;
        out_mem_wr_en   = 1'b0;
        out_mem_wr_data = '0;
        out_done        = 1'b0;
        out_busy        = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                out_req_ready = !in_rst && !fifo_full && !last_seen;
                out_mem_wr_en = !in_rst && !fifo_empty;
                if (!fifo_empty) begin
                    out_mem_wr_data = fifo_head[INSTR_W-1:0];
                end
            end
            ST_DONE: out_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            addr      <= '0;
            count     <= '0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        addr      <= in_base_addr;
                        count     <= '0;
                        last_seen <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && in_req_last) begin
                        last_seen <= 1'b1;
                    end
                    if (write_fire) begin
                        addr <= addr + 1'b1;
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_mem_addr = addr;
    assign out_count    = count;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer end of the opcode interface decoded by the control unit.
- Accepts instruction requests (ALU op class, immediate flag, register/immediate fields) over a valid/ready handshake.
- Encodes each request into an instruction word with the 5-bit opcode map, buffers it in a small FIFO, and writes it sequentially into instruction memory from a base address.
- Used by the boot/program-load path to fill instruction memory before the core runs.

Parameters:
- INSTR_W, 32, instruction word width.
- REG_AW, 5, register index width.
- ADDR_W, 8, instruction memory address width.
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, ≥2).
- Derived localparam IMM_W = INSTR_W-5-2*REG_AW (17 at defaults).

Ports:
- in_clk  in  1  clock; single clock domain, all logic on rising edge.
- in_rst  in  1  synchronous, active-high reset.
- in_start  in  1  begin load session (honoured in IDLE only).
- in_base_addr  in  ADDR_W  first write address, sampled with in_start.
- in_req_valid  in  1  request valid.
- out_req_ready  out  1  request accepted when valid&&ready.
- in_req_nop  in  1  encode no-op.
- in_req_alu_op  in  2  0=add, 1=sub, 2=and, 3=or.
- in_req_use_imm  in  1  immediate form.
- in_req_rd  in  REG_AW  destination register.
- in_req_rs  in  REG_AW  source register 1.
- in_req_rt  in  REG_AW  source register 2 (register form).
- in_req_imm  in  IMM_W  immediate (immediate form).
- in_req_last  in  1  final request of session.
- out_mem_wr_en  out  1  write request.
- out_mem_addr  out  ADDR_W  write address.
- out_mem_wr_data  out  INSTR_W  encoded word.
- in_mem_ready  in  1  memory accepts write when wr_en&&ready.
- out_busy  out  1  state != IDLE.
- out_done  out  1  one-cycle pulse at session end.
- out_count  out  ADDR_W+1  words written this session.

Behaviour:
- Encoding:
  - opcode = nop ? 0 : 1 + alu_op + (use_imm ? 4 : 0), giving add=1, sub=2, and=3, or=4, addi=5, subi=6, andi=7, ori=8.
  - word = {opcode, rd, rs, operand}; operand = use_imm ? imm : zero-extended rt.
  - A nop word is all zeros; every field is ignored.
- States: IDLE, LOAD, DONE.
  - IDLE: in_start=1 → LOAD next cycle; addr←in_base_addr, count←0, last_seen←0.
  - LOAD: out_req_ready = !fifo_full && !last_seen.
    - On accept: encode, push the word and its last flag into the FIFO.
    - If in_req_last is set on the accepted request: last_seen←1.
    - out_mem_wr_en = !fifo_empty; addr/data come from the FIFO head.
    - On wr_en&&in_mem_ready: pop, addr←addr+1 (wraps 2^ADDR_W-1→0), count←count+1 (saturates at all-ones).
    - If the popped word carries the last flag → DONE.
  - DONE: out_done=1 for exactly one cycle, → IDLE. out_count holds its value until the next in_start.
- Latency: a request accepted in cycle N is presented on out_mem_wr_en no earlier than N+1 (registered FIFO). Throughput is 1 word/cycle with in_mem_ready held high.
- FIFO full: ready=0 even if a pop occurs that cycle; no combinational ready-from-pop path.
- Backpressure: while wr_en=1 and in_mem_ready=0, addr and data hold stable.
- in_start outside IDLE is ignored. in_req_valid outside LOAD is ignored (ready=0).
- Reset values, and the result of reset asserted at any point including mid-session:
  - state=IDLE, FIFO emptied, last_seen=0.
  - out_req_ready=0, out_mem_wr_en=0, out_mem_addr=0, out_mem_wr_data=0, out_busy=0, out_done=0, out_count=0.
  - No write is issued in the reset cycle.

Decomposition:
- Shared package:
  - opcode constants OP_NOP..OP_ORI (0..8), shared with the control unit.
  - ALU op codes ALU_ADD..ALU_OR.
  - Instruction field position/width constants.
  - State encoding.
- One sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty). Stores {last, word}.

Test Plan:
- start base=0x10; add rd=1 rs=2 rt=3, then subi rd=4 rs=5 imm=0x1FFFF last; mem_ready=1 → 0x08440003 @0x10, 0x310BFFFF @0x11; done pulses once; count=2; busy falls after done.
- nop with use_imm=1 imm=5 rd=7, last → word 0x00000000 written; opcode field 0.
- ori rd=1 rs=1 imm=0x00FF (op=3, imm) → opcode 8, word 0x404200FF.
- mem_ready=0, 6 valid requests → exactly 4 accepted, ready=0 afterwards; addr/data stable; release mem_ready → 4 writes in consecutive cycles, then remaining 2 accepted.
- base=0xFF, 2 requests → writes at 0xFF then 0x00; count=2.
- Reset asserted after 1 of 3 writes → next cycle all outputs 0, state IDLE; new start base=0x20 completes normally from 0x20 with count restarting at 0.
